l2cache_control: RTL
====================

# l2cache_control

Sequencing FSM for the 2-way set-associative L2 cache: 23-bit tag, 4-bit index, 5-bit offset, 256-bit lines.
- Accepts one read or write request at a time from the L1 side and consumes the tag-comparison result (hit, hit way) from the L2 tag comparator.
- Drives load/select strobes into the L2 tag, data, valid, dirty and LRU arrays.
- Runs writeback and fill transactions on the physical-memory port.
- Keeps hit and miss counters for performance analysis.

## Interface
Parameters:
- PERF_W, 32, width of hit_count / miss_count

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- l1_read  in  1  read request, held high until l1_resp
- l1_write  in  1  write request, held high until l1_resp
- l1_resp  out  1  one-cycle completion pulse
- hit  in  1  tag comparator hit
- hit_way  in  1  tag comparator hit way (0/1)
- lru_way  in  1  LRU array output for the addressed set (way to evict)
- dirty_0, dirty_1  in  1 each  dirty bits of the addressed set
- pmem_resp  in  1  memory transaction complete (one-cycle pulse)
- pmem_read  out  1  memory line read request
- pmem_write  out  1  memory line write request
- pmem_addr_sel  out  1  0 = request address, 1 = victim {tag, index, 5'b0}
- way_sel  out  1  way addressed by array writes / victim data mux
- data_in_sel  out  1  0 = line from pmem, 1 = L1 write data merged with byte enables
- load_data, load_tag, set_valid, set_dirty, clr_dirty  out  1 each  array write strobes for way_sel
- load_lru  out  1  LRU write strobe
- lru_in  out  1  value written to LRU (the way *not* just used)
- hit_count, miss_count  out  PERF_W each  saturating performance counters

## Operation
- States: IDLE, CHECK, WRITEBACK, FILL. Outputs are combinational from state and inputs; victim, refill and counters are registered.
- IDLE
  - All strobes are 0.
  - l1_read or l1_write goes to CHECK; arrays are addressed by the request index this cycle.
  - Both high together is treated as a write.
- CHECK with hit=1
  - l1_resp=1, load_lru=1, lru_in=~hit_way, next state IDLE.
  - On a write, additionally: way_sel=hit_way, load_data=1, data_in_sel=1, set_dirty=1.
- CHECK with hit=0
  - Latch victim<=lru_way.
  - Go to WRITEBACK if the dirty bit of lru_way is 1, else go to FILL.
  - No l1_resp.
- WRITEBACK
  - pmem_write=1, pmem_addr_sel=1, way_sel=victim.
  - Stay until pmem_resp, then go to FILL.
- FILL
  - pmem_read=1, pmem_addr_sel=0, way_sel=victim.
  - On pmem_resp, for one cycle: load_data=1, data_in_sel=0, load_tag=1, set_valid=1, clr_dirty=1. Set refill<=1, next state CHECK.
- The re-check after a fill must hit and completes the request exactly as a hit does; a write miss therefore merges its data and sets dirty in that cycle.
- Counters
  - On entry to CHECK with refill=0: hit_count+1 if hit, else miss_count+1.
  - Nothing is counted when refill=1; refill clears on leaving CHECK.
  - Both counters saturate at all-ones and never wrap.
- pmem_resp is ignored in IDLE and CHECK.
- L1 request lines are not sampled outside IDLE; a request dropped mid-transaction is an L1 protocol violation, and the FSM completes the transaction anyway.

## Timing
- Reset values (asynchronous on rst_n low): state IDLE, victim 0, refill 0, counters 0. Every output is 0 while in reset and in IDLE.
- Reset mid-transaction: pmem_read/pmem_write drop in the same cycle and no array strobe fires. The memory side must tolerate the abandoned transaction.
- Hit latency: request seen in cycle 0 (IDLE), l1_resp in cycle 1 (CHECK).
- Clean miss: IDLE, CHECK, FILL for N cycles through pmem_resp, then CHECK with l1_resp. l1_resp arrives 3 cycles plus the memory wait.
- Dirty miss: adds WRITEBACK ahead of FILL. pmem_read never asserts in the same cycle as pmem_write.
- pmem_read/pmem_write stay high continuously until pmem_resp is sampled, and drop the cycle after.
- l1_resp is exactly one cycle wide per request. Back-to-back requests cost at least one IDLE cycle between them.

## Test plan
- Reset: hold rst_n=0, then release → every output 0, hit_count=0, miss_count=0, state IDLE.
- Read hit: set 3 way 1 valid with a matching tag; l1_read=1, hit=1, hit_way=1 → l1_resp in cycle 1, load_lru=1 with lru_in=0, hit_count=1, no pmem activity.
- Clean read miss: lru_way=0, dirty_0=0, pmem_resp after 5 cycles → pmem_read high 5 cycles with addr_sel=0, then load_tag/load_data/set_valid on way 0, then CHECK hit → l1_resp. miss_count=1, hit_count unchanged.
- Dirty write miss: lru_way=1, dirty_1=1 → pmem_write with addr_sel=1 and way_sel=1 until pmem_resp, then FILL, then re-check with load_data, data_in_sel=1, set_dirty → l1_resp.
- Async reset during FILL (pmem_read=1) → pmem_read is 0 immediately with no strobes. After release, a new l1_read starts from IDLE.
- Counter saturation: with PERF_W=4, run 20 read hits → hit_count holds at 15.

Source files
------------

// File: rtl/l2cache_control_if.sv
// Handshake and strobe bundle between the L2 sequencing FSM and the
// L1 request side, tag comparator, cache arrays and physical memory port.
interface l2cache_control_if;
  // L1 request side
  logic l1_read;
  logic l1_write;
  logic l1_resp;
  // tag comparator / array status for the addressed set
  logic hit;
  logic hit_way;
  logic lru_way;
  logic dirty_0;
  logic dirty_1;
  // physical memory port
  logic pmem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_addr_sel;
  // array control
  logic way_sel;
  logic data_in_sel;
  logic load_data;
  logic load_tag;
  logic set_valid;
  logic set_dirty;
  logic clr_dirty;
  logic load_lru;
  logic lru_in;

  // controller side
  modport master (
    input  l1_read, l1_write, hit, hit_way, lru_way, dirty_0, dirty_1, pmem_resp,
    output l1_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_in_sel,
           load_data, load_tag, set_valid, set_dirty, clr_dirty, load_lru, lru_in
  );

  // environment side (L1, comparator, arrays, memory)
  modport slave (
    output l1_read, l1_write, hit, hit_way, lru_way, dirty_0, dirty_1, pmem_resp,
    input  l1_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_in_sel,
           load_data, load_tag, set_valid, set_dirty, clr_dirty, load_lru, lru_in
  );
endinterface

// File: rtl/l2cache_control.sv
// Sequencing FSM for the 2-way set-associative L2 cache.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | waiting for an L1 read/write; all strobes low
//   CHECK     | tag compare result valid; hit completes, miss picks victim
//   WRITEBACK | dirty victim line being written to memory
//   FILL      | requested line being read from memory into the victim way
//
// After a fill the FSM returns to CHECK, which must then hit and finishes
// the request exactly like an ordinary hit (write misses merge there).
module l2cache_control #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  l2cache_control_if.master bus,
  output logic [PERF_W-1:0] hit_count,
  output logic [PERF_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHECK     = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   victim;
  logic   refill;
  logic   is_write;
  logic   victim_dirty;

  assign victim_dirty = bus.lru_way ? bus.dirty_1 : bus.dirty_0;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // request type, victim way and refill marker; request lines only sampled in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write <= 1'b0;
      victim   <= 1'b0;
      refill   <= 1'b0;
    end else begin
      if (state == IDLE && (bus.l1_read || bus.l1_write))
        is_write <= bus.l1_write;
      if (state == CHECK && !bus.hit)
        victim <= bus.lru_way;
      if (state == FILL && bus.pmem_resp)
        refill <= 1'b1;
      else if (state == CHECK)
        refill <= 1'b0;
    end
  end

  // saturating hit/miss counters, counted once per request on the first CHECK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == CHECK && !refill) begin
      if (bus.hit) begin
        if (hit_count != '1) hit_count <= hit_count + PERF_W'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + PERF_W'(1);
      end
    end
  end

  // next-state and combinational strobes
  always_comb begin
    state_nxt         = state;
    bus.l1_resp       = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.way_sel       = 1'b0;
    bus.data_in_sel   = 1'b0;
    bus.load_data     = 1'b0;
    bus.load_tag      = 1'b0;
    bus.set_valid     = 1'b0;
    bus.set_dirty     = 1'b0;
    bus.clr_dirty     = 1'b0;
    bus.load_lru      = 1'b0;
    bus.lru_in        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.l1_read || bus.l1_write) state_nxt = CHECK;
      end
      CHECK: begin
        if (bus.hit) begin
          bus.l1_resp  = 1'b1;
          bus.load_lru = 1'b1;
          bus.lru_in   = ~bus.hit_way;
          if (is_write) begin
            bus.way_sel     = bus.hit_way;
            bus.load_data   = 1'b1;
            bus.data_in_sel = 1'b1;
            bus.set_dirty   = 1'b1;
          end
          state_nxt = IDLE;
        end else begin
          state_nxt = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.way_sel       = victim;
        if (bus.pmem_resp) state_nxt = FILL;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim;
        if (bus.pmem_resp) begin
          bus.load_data = 1'b1;
          bus.load_tag  = 1'b1;
          bus.set_valid = 1'b1;
          bus.clr_dirty = 1'b1;
          state_nxt     = CHECK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
